// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared definitions for the sequential chunked adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   DEF_WIDTH : default operand width
//   DEF_CHUNK : default slice width processed per clock
//   clog2()   : ceiling log2, used to size the slice index counter
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder built from
// full-adder cells.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (for two's-complement overflow)
module chunk_adder
  import seq_add_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit adder that processes one CHUNK-bit slice per
// clock with a registered carry between slices.
//
// Optional feature macro: SEQADD_SUB_EN (adds the sub port, A - B mode).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operation request
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   sub        : subtract select (only with SEQADD_SUB_EN)
//   busy       : slices are being processed
//   done       : one-cycle pulse, result valid
//   s          : sum, stable from done until the next accepting edge
//   cout       : carry out of the MSB (in subtract mode: 1 = no borrow)
//   ovf        : two's-complement overflow
//   dbg_state  : current controller state, for observation only
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE); the edge
// that sees start=1 there is the accepting edge and latches a/b/cin(/sub).
// start while busy=1 is dropped, not queued. done is high for exactly the
// one cycle spent in DONE; holding start high through DONE issues the next
// operation on the edge that leaves DONE.
module seq_chunk_adder
  import seq_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t            state;
  state_t            nstate;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;

  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [CHUNK-1:0]  sum_sl;
  logic              cout_sl;
  logic              cmsb_sl;
  logic              accept;
  logic              last;

  // Operand capture values; in subtract mode B is inverted and the +1 of
  // the two's complement enters through the carry register.
  logic [WIDTH-1:0]  b_load;
  logic              c_load;

`ifdef SEQADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign accept = start && (state != RUN);
  assign last   = (idx == LAST);

  // Slice select from the captured operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_r[i*CHUNK +: CHUNK];
        b_sl = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .s    (sum_sl),
    .cout (cout_sl),
    .cmsb (cmsb_sl)
  );

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        a_r   <= a;
        b_r   <= b_load;
        carry <= c_load;
        idx   <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx == IW'(i)) s[i*CHUNK +: CHUNK] <= sum_sl;
        end
        carry <= cout_sl;
        idx   <= idx + 1'b1;
        if (last) begin
          cout <= cout_sl;
          ovf  <= cmsb_sl ^ cout_sl;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
